// File: rtl/mem_byte_port.sv
// Byte-serial memory responder: accepts a latched request and walks a byte-wide RAM one byte per cycle.
// Define VECTOR_WP_EN to reject byte writes to the exception-vector bytes (VEC_BASE..DEPTH-1).
module mem_byte_port #(
  parameter int DEPTH    = 256,
  parameter int VEC_BASE = DEPTH - 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        wr,
  input  logic        size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    cnt;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic          size_q;
  logic          err_q;
  logic [31:0]   wdata_q;

  logic          reject;
  logic          wp_hit;
  logic          last;
  logic          mem_we;
  logic [1:0]    lane;
  logic [AW-1:0] byte_addr;
  logic [7:0]    wbyte;
  logic [7:0]    mem_rd;

  logic [7:0]    mem [DEPTH];

  // Request classification happens on the live inputs in the accepting cycle.
  always_comb begin
    // NOTE: assign a default before any condition so no path leaves the signal unassigned (no latch).
    reject = 1'b0;
    if (addr >= 32'(DEPTH))
      reject = 1'b1;
    else if (size && (addr > 32'(DEPTH - 4) || addr >= 32'(VEC_BASE)))
      reject = 1'b1;
  end

`ifdef VECTOR_WP_EN
  assign wp_hit = wr && !size && (addr >= 32'(VEC_BASE)) && (addr < 32'(DEPTH));
`else
  assign wp_hit = 1'b0;
`endif

  // Big-endian lanes: cnt=0 of a word maps to bits [31:24]; byte mode always uses lane 0.
  assign lane      = size_q ? ~cnt : 2'd0;
  assign byte_addr = addr_q + AW'(cnt);
  assign wbyte     = wdata_q[{lane, 3'b000} +: 8];
  assign mem_rd    = mem[byte_addr];
  assign last      = !size_q || (cnt == 2'd3);
  assign mem_we    = (state == XFER) && wr_q && !err_q;

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = done && err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      size_q  <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= 32'h0;
      rdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr[AW-1:0];
            wr_q    <= wr;
            size_q  <= size;
            wdata_q <= wdata;
            err_q   <= reject || wp_hit;
            rdata   <= 32'h0;
            cnt     <= 2'd0;
            state   <= reject ? DONE : XFER;
          end
        end
        XFER: begin
          if (!wr_q)
            rdata[{lane, 3'b000} +: 8] <= mem_rd;
          cnt <= cnt + 2'd1;
          if (last)
            state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // NOTE: the RAM array is deliberately not reset; its contents survive reset_n.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[byte_addr] <= wbyte;
  end

endmodule

// File: tb/tb_mem_byte_port.sv
// Self-checking bench for mem_byte_port: directed steps plus random traffic against a byte-array model.
module tb_mem_byte_port;

  localparam int DEPTH    = 256;
  localparam int VEC_BASE = DEPTH - 3;
`ifdef VECTOR_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req;
  logic        wr;
  logic        size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  mem_byte_port #(.DEPTH(DEPTH), .VEC_BASE(VEC_BASE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .err     (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  ref_mem   [DEPTH];
  bit          ref_known [DEPTH];
  logic [31:0] last_rdata;
  logic [31:0] last_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: whole-access view, edges from acceptance to done, and RAM side effects.
  task automatic model_access(input bit w, input bit sz, input logic [31:0] a, input logic [31:0] wd,
                              output bit e, output int lat, output logic [31:0] rd, output bit known);
    longint ua;
    int     n;
    int     b;
    ua    = a;
    n     = sz ? 4 : 1;
    e     = 1'b0;
    lat   = 0;
    rd    = 32'h0;
    known = 1'b1;
    if (ua >= DEPTH || (sz && ua > DEPTH - 4) || (sz && ua >= VEC_BASE)) begin
      e = 1'b1;
      return;
    end
    lat = n;
    if (WP && w && !sz && ua >= VEC_BASE) begin
      e = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      b = int'(ua) + i;
      if (w) begin
        ref_mem[b]   = sz ? wd[8*(3-i) +: 8] : wd[7:0];
        ref_known[b] = 1'b1;
      end else begin
        rd    = (rd << 8) | 32'(ref_mem[b]);
        known = known & ref_known[b];
      end
    end
  endtask

  task automatic do_access(input bit w, input bit sz, input logic [31:0] a, input logic [31:0] wd);
    bit          e;
    int          lat;
    logic [31:0] rd;
    bit          known;
    int          k;
    string       p;
    p = $sformatf("%s%s@%0h", w ? "W" : "R", sz ? "w" : "b", a);
    model_access(w, sz, a, wd, e, lat, rd, known);
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'($urandom); size = 1'($urandom); addr = $urandom; wdata = $urandom;
    check({p, ".busy1"}, 32'(busy), 32'd1);
    k = 0;
    while (done !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({p, ".lat"}, k, lat);
    check({p, ".busy"}, 32'(busy), 32'd1);
    check({p, ".err"}, 32'(err), 32'(e));
    if (known) check({p, ".rdata"}, rdata, rd);
    last_rdata = rdata;
    last_err   = 32'(err);
    @(posedge clk); #1;
    check({p, ".pulse"}, 32'(done), 32'd0);
    check({p, ".idle"}, 32'(busy), 32'd0);
    if (known) check({p, ".hold"}, rdata, rd);
  endtask

  initial begin
    bit          e;
    int          lat;
    logic [31:0] rd;
    logic [31:0] exp8;
    logic [31:0] prior;
    bit          known;
    int          n_done;
    bit          saw_done;
    int          r;
    logic [31:0] a;

    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]   = 8'h00;
      ref_known[i] = 1'b0;
    end
    req = 1'b0; wr = 1'b0; size = 1'b0; addr = 32'h0; wdata = 32'h0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.rdata", rdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill the RAM through the port so the model knows every writable byte.
    for (int i = 0; i < DEPTH; i++)
      do_access(1'b1, 1'b0, 32'(i), $urandom);

    // Word write then word read at 8, with byte-read cross-checks.
    do_access(1'b1, 1'b1, 32'd8, 32'h11223344);
    do_access(1'b0, 1'b1, 32'd8, 32'h0);
    check("w8.const", last_rdata, 32'h11223344);
    do_access(1'b0, 1'b0, 32'd8, 32'h0);
    check("b8.const", last_rdata, 32'h00000011);
    do_access(1'b0, 1'b0, 32'd11, 32'h0);
    check("b11.const", last_rdata, 32'h00000044);

    // Vector byte write / read.
`ifdef VECTOR_WP_EN
    do_access(1'b0, 1'b0, 32'd253, 32'h0);
    prior = last_rdata;
    do_access(1'b1, 1'b0, 32'd253, 32'h000000A5);
    check("wp.err", last_err, 32'd1);
    do_access(1'b0, 1'b0, 32'd253, 32'h0);
    check("wp.keep", last_rdata, prior);
    check("wp.rd_err", last_err, 32'd0);
`else
    do_access(1'b1, 1'b0, 32'd253, 32'h000000A5);
    do_access(1'b0, 1'b0, 32'd253, 32'h0);
    check("vec.rdata", last_rdata, 32'h000000A5);
    check("vec.err", last_err, 32'd0);
`endif

    // Rejected requests, then confirm the boundary bytes are intact.
    do_access(1'b0, 1'b1, 32'd253, 32'h0);
    check("rej253.err", last_err, 32'd1);
    do_access(1'b0, 1'b1, 32'd254, 32'h0);
    check("rej254.err", last_err, 32'd1);
    do_access(1'b0, 1'b0, 32'h100, 32'h0);
    check("rej100.err", last_err, 32'd1);
    do_access(1'b1, 1'b0, 32'h100, 32'hFFFFFFFF);
    do_access(1'b1, 1'b1, 32'd254, 32'hDEADBEEF);
    check("rejw254.err", last_err, 32'd1);
    check("rejw254.rdata", last_rdata, 32'h0);
    do_access(1'b0, 1'b0, 32'd254, 32'h0);
    do_access(1'b0, 1'b0, 32'd255, 32'h0);
    do_access(1'b0, 1'b0, 32'd0, 32'h0);

    // Boundary word read at DEPTH-4.
    do_access(1'b0, 1'b1, 32'd252, 32'h0);
    check("b252.err", last_err, 32'd0);

    // req held high through word reads; address/data scrambled mid-transfer.
    do_access(1'b1, 1'b1, 32'd12, 32'hCAFE1234);
    model_access(1'b0, 1'b1, 32'd8, 32'h0, e, lat, exp8, known);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 1'b1; addr = 32'd8; wdata = 32'h0;
    n_done = 0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      if (i % 6 == 1) begin addr = 32'd12; wdata = $urandom; end
      if (i % 6 == 3) addr = 32'd8;
      if (done === 1'b1) begin
        n_done++;
        check("hold.rdata", rdata, exp8);
      end
    end
    req = 1'b0;
    check("hold.ndone", n_done, 3);

    // Reset during cnt=2 of a word write to 16.
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 1'b1; addr = 32'd16; wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid.busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid.rst_busy", 32'(busy), 32'd0);
    check("mid.rst_done", 32'(done), 32'd0);
    check("mid.rst_err", 32'(err), 32'd0);
    check("mid.rst_rdata", rdata, 32'h0);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("mid.nodone", 32'(saw_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ref_mem[16] = 8'hA1;
    ref_mem[17] = 8'hB2;
    for (int i = 16; i < 20; i++)
      do_access(1'b0, 1'b0, 32'(i), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h100 + 32'($urandom_range(0, 1000));
      else if (r == 1) a = $urandom;
      else if (r < 4)  a = 32'($urandom_range(248, 255));
      else             a = 32'($urandom_range(0, 255));
      do_access(1'($urandom), 1'($urandom), a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_byte_port.md
# mem_byte_port

Byte-serial memory responder on the far side of the CPU's instruction-or-data address mux: it accepts the selected 32-bit address plus a request, performs the access against an internal byte-wide RAM one byte per cycle, and returns the assembled word. The top three byte addresses are the exception-vector bytes, which the control unit fetches in byte mode during exception entry. It replaces the single-cycle memory model so that multi-cycle access latency is exercised by the control FSM.

## Interface
- DEPTH, 256, RAM size in bytes; valid addresses are 0..DEPTH-1
- VEC_BASE, DEPTH-3, first exception-vector byte address; vectors live at VEC_BASE..DEPTH-1
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  1  start request, sampled only in IDLE
- wr  in  1  1 = write, 0 = read; latched with req
- size  in  1  1 = word (4 bytes), 0 = byte; latched with req
- addr  in  32  byte address from the address mux; latched with req
- wdata  in  32  write data; latched with req
- busy  out  1  high from the cycle after acceptance through DONE
- done  out  1  one-cycle completion pulse
- rdata  out  32  read result, valid while done=1 and held until the next acceptance
- err  out  1  valid with done; access rejected

## Operation
- States: IDLE, XFER, DONE. Byte counter cnt is 2 bits.
- IDLE: if req=1, latch addr/wr/size/wdata, then classify.
  - Out of range (addr >= DEPTH) goes to DONE with err=1.
  - Word access with addr > DEPTH-4 goes to DONE with err=1.
  - Word access to any vector address goes to DONE with err=1.
  - Any other request goes to XFER with cnt=0.
- XFER: one byte per cycle at address latched_addr+cnt.
  - Byte order is big-endian: byte at addr maps to rdata[31:24] in word mode.
  - Byte-mode read: byte zero-extended into rdata[7:0].
  - Word write: wdata[31:24] goes to addr, wdata[7:0] to addr+3.
  - Byte write: wdata[7:0] goes to addr.
  - The last byte is cnt=3 (word) or cnt=0 (byte); it goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - err=1 only in DONE cycles of rejected requests.
  - A rejected access leaves the RAM unmodified and rdata=0.
- req is ignored outside IDLE. It is not queued.
- Reset clears state, cnt, busy, done, err and rdata to 0. RAM contents are retained across reset and are not initialised.
- Reset mid-XFER aborts the access. Bytes already written stay written; no done is issued.

## Timing
- Request sampled at edge T0 (IDLE).
- Word access: XFER at T1..T4, done=1 at T5, busy=1 over T1..T5.
- Byte access: XFER at T1, done=1 at T2.
- Rejected access: done=1 (err=1) at T1.
- Earliest next acceptance is the edge after DONE (IDLE cycle). Back-to-back word reads therefore take 6 cycles each.
- Reset values: busy=0, done=0, err=0, rdata=32'h0.

## Configuration
- VECTOR_WP_EN defined:
  - Byte writes to VEC_BASE..DEPTH-1 are rejected: err=1, no RAM change, done at T2 with the normal byte-access latency.
  - Vector reads are unaffected.
- VECTOR_WP_EN undefined: byte writes to vector addresses behave like any other byte write.

## Test plan
- Word write wdata=32'h11223344 at addr 8, then word read at addr 8.
  - Timing: done at T5 for each access.
  - Data: rdata=32'h11223344.
  - Byte-read cross-check: addr 8 returns 32'h11, addr 11 returns 32'h44.
- Byte write 8'hA5 to addr 253, then byte read at addr 253.
  - Without VECTOR_WP_EN: rdata=32'h000000A5, err=0.
  - With VECTOR_WP_EN: the write gives err=1, and the read returns the prior value.
- Request errors, each giving done with err=1 at T1, rdata=0, RAM unchanged:
  - word read at addr 253;
  - word read at addr 254;
  - any access at addr 32'h100;
  - word write at addr 254.
- Ignored requests: hold req=1 continuously through a word read.
  - Exactly one done per 6 cycles.
  - Mid-transfer changes to addr and wdata have no effect.
- Reset mid-transfer:
  - Assert reset_n=0 during XFER cnt=2 of a word write to addr 16.
  - Response: busy, done, err and rdata go to 0 immediately, with no done.
  - Bytes 16..17 are updated; bytes 18..19 are unchanged.
- Boundary access: word read at addr DEPTH-4 = 252 succeeds, err=0; rdata holds bytes 252..255.
